// File: rtl/regbank_s4_byte_feeder.sv
// Assembles a header/immediate byte pair into a 12-bit register-bank instruction.
// Latency: one cycle from the immediate byte to the inst_en_o pulse; all outputs registered.
// No back-pressure: every byte_en_i cycle is consumed; a stalled pair times out, a bad header latches error.
module regbank_s4_byte_feeder #(
  parameter int unsigned TIMEOUT = 16  // idle cycles tolerated between header and immediate (1..255)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_i,
  input  logic        byte_en_i,
  output logic [11:0] inst_o,
  output logic        inst_en_o,
  output logic        busy_o,
  output logic        drop_o,
  output logic        error_o
);

  // Two-bit state; every encoding is named, but the default arm still traps to Error.
  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  // Last count value before a pending header is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q,   state_d;
  logic [3:0]  code_q,    code_d;
  logic [7:0]  cnt_q,     cnt_d;
  logic [11:0] inst_q,    inst_d;
  logic        inst_en_q, inst_en_d;
  logic        busy_q,    busy_d;
  logic        drop_q,    drop_d;
  logic        error_q,   error_d;

  // Next-state and output decode; pulses default low so they last one cycle.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    inst_d    = inst_q;
    inst_en_d = 1'b0;
    busy_d    = busy_q;
    drop_d    = 1'b0;
    error_d   = error_q;

    case (state_q)
      // One dead cycle after reset; any byte offered now is lost.
      ST_RESET: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      // Waiting for a header; only codes with a zero upper nibble are legal headers.
      ST_IDLE: begin
        if (byte_en_i) begin
          if (byte_i[7:4] == 4'h0) begin
            code_d  = byte_i[3:0];
            cnt_d   = 8'd0;
            busy_d  = 1'b1;
            state_d = ST_WAIT;
          end else begin
            inst_d  = 12'h000;
            busy_d  = 1'b0;
            error_d = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end

      // Header held; the immediate wins over a timeout landing in the same cycle.
      ST_WAIT: begin
        if (byte_en_i) begin
          inst_d    = {code_q, byte_i};
          inst_en_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          drop_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // Sticky until reset; all input bytes are ignored.
      ST_ERROR: begin
        inst_d  = 12'h000;
        busy_d  = 1'b0;
        error_d = 1'b1;
        state_d = ST_ERROR;
      end

      default: begin
        inst_d  = 12'h000;
        busy_d  = 1'b0;
        error_d = 1'b1;
        state_d = ST_ERROR;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_RESET;
      code_q    <= 4'h0;
      cnt_q     <= 8'd0;
      inst_q    <= 12'h000;
      inst_en_q <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      inst_q    <= inst_d;
      inst_en_q <= inst_en_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
      error_q   <= error_d;
    end
  end

  assign inst_o    = inst_q;
  assign inst_en_o = inst_en_q;
  assign busy_o    = busy_q;
  assign drop_o    = drop_q;
  assign error_o   = error_q;

  // Human-readable input and state strings for the waveform viewer.
  string d_Input;
  string d_State;

  // Debug text only; nothing in the datapath depends on it.
  always_comb begin
    d_Input = "NN";
    d_State = "?";
    if (byte_en_i) d_Input = $sformatf("EN %2X", byte_i);
    case (state_q)
      ST_RESET: d_State = "X";
      ST_IDLE:  d_State = "I";
      ST_WAIT:  d_State = $sformatf("W %1X %0d", code_q, cnt_q);
      ST_ERROR: d_State = "E";
      default:  d_State = "?";
    endcase
  end

endmodule

// File: tb/tb_regbank_s4_byte_feeder.sv
// Directed scenarios followed by randomized traffic, all checked every cycle against a pair-assembly model.
module tb_regbank_s4_byte_feeder;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  byte_i;
  logic        byte_en_i;
  logic [11:0] inst_o;
  logic        inst_en_o, busy_o, drop_o, error_o;

  int tests = 0;
  int fails = 0;

  regbank_s4_byte_feeder #(.TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .byte_i    (byte_i),
    .byte_en_i (byte_en_i),
    .inst_o    (inst_o),
    .inst_en_o (inst_en_o),
    .busy_o    (busy_o),
    .drop_o    (drop_o),
    .error_o   (error_o)
  );

  always #5 clock = ~clock;

  // Reference model: protocol-level view of a byte pair being collected.
  logic [11:0] m_inst;
  logic        m_inst_en, m_drop, m_err;
  logic        m_lost;      // next cycle is the post-reset dead cycle
  logic        m_pending;   // header received, immediate outstanding
  logic [3:0]  m_code;
  int          m_waited;    // idle cycles seen since the header
  int          inst_pulses;
  int          drop_pulses;

  task automatic model_update(input logic rst, input logic en, input logic [7:0] b);
    m_inst_en = 1'b0;
    m_drop    = 1'b0;
    if (rst) begin
      m_lost = 1'b1; m_pending = 1'b0; m_err = 1'b0; m_inst = 12'h000; m_waited = 0;
    end else if (m_lost) begin
      m_lost = 1'b0;
    end else if (!m_err) begin
      if (m_pending) begin
        if (en) begin
          m_inst = {m_code, b}; m_inst_en = 1'b1; m_pending = 1'b0;
        end else begin
          m_waited++;
          if (m_waited == TO) begin
            m_pending = 1'b0; m_drop = 1'b1;
          end
        end
      end else if (en) begin
        if (b < 8'd16) begin
          m_pending = 1'b1; m_code = b[3:0]; m_waited = 0;
        end else begin
          m_err = 1'b1; m_inst = 12'h000;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after it.
  task automatic step(input logic rst, input logic en, input logic [7:0] b);
    reset = rst; byte_en_i = en; byte_i = b;
    @(posedge clock);
    model_update(rst, en, b);
    #1;
    if (inst_en_o === 1'b1) inst_pulses++;
    if (drop_o === 1'b1) drop_pulses++;
    chk("inst",    inst_o,           m_inst);
    chk("inst_en", {11'd0, inst_en_o}, {11'd0, m_inst_en});
    chk("busy",    {11'd0, busy_o},    {11'd0, m_pending});
    chk("drop",    {11'd0, drop_o},    {11'd0, m_drop});
    chk("error",   {11'd0, error_o},   {11'd0, m_err});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b1; byte_en_i = 1'b0; byte_i = 8'h00;
    m_lost = 1'b1; m_pending = 1'b0; m_err = 1'b0; m_inst = 12'h000;
    m_inst_en = 1'b0; m_drop = 1'b0; m_code = 4'h0; m_waited = 0;
    inst_pulses = 0; drop_pulses = 0;

    // Reset state
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h02);
    chk("rst_inst", inst_o, 12'h000);
    chk("rst_flags", {8'd0, inst_en_o, busy_o, drop_o, error_o}, 12'h000);

    // Simple pair right after the dead cycle
    step(1'b0, 1'b1, 8'h02);            // lost in the Reset cycle
    chk("lost_busy", {11'd0, busy_o}, 12'h000);
    step(1'b0, 1'b1, 8'h02);
    chk("t1_busy", {11'd0, busy_o}, 12'h001);
    step(1'b0, 1'b1, 8'h5A);
    chk("t1_inst", inst_o, 12'h25A);
    chk("t1_en", {11'd0, inst_en_o}, 12'h001);
    chk("t1_busy_lo", {11'd0, busy_o}, 12'h000);
    step(1'b0, 1'b0, 8'h00);
    chk("t1_en_lo", {11'd0, inst_en_o}, 12'h000);
    chk("t1_hold", inst_o, 12'h25A);

    // Gapless stream of two instructions
    inst_pulses = 0;
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h03);
    chk("t2_first", inst_o, 12'h103);
    step(1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b1, 8'h77);
    chk("t2_second", inst_o, 12'h377);
    chk("t2_pulses", 12'(inst_pulses), 12'd2);

    // Timeout after exactly TIMEOUT idle cycles
    drop_pulses = 0; inst_pulses = 0;
    step(1'b0, 1'b1, 8'h04);
    idle(TO - 1);
    chk("t3_no_drop_yet", {11'd0, drop_o}, 12'h000);
    idle(1);
    chk("t3_drop", {11'd0, drop_o}, 12'h001);
    chk("t3_busy", {11'd0, busy_o}, 12'h000);
    idle(1);
    chk("t3_drop_once", 12'(drop_pulses), 12'd1);
    chk("t3_no_inst", 12'(inst_pulses), 12'd0);
    step(1'b0, 1'b1, 8'h05);
    step(1'b0, 1'b1, 8'h11);
    chk("t3_inst", inst_o, 12'h511);

    // Immediate on the last allowed cycle beats the timeout
    drop_pulses = 0;
    step(1'b0, 1'b1, 8'h04);
    idle(TO - 1);
    step(1'b0, 1'b1, 8'hC3);
    chk("t4_inst", inst_o, 12'h4C3);
    chk("t4_en", {11'd0, inst_en_o}, 12'h001);
    idle(2);
    chk("t4_no_drop", 12'(drop_pulses), 12'd0);

    // Bad header latches error until reset
    inst_pulses = 0;
    step(1'b0, 1'b1, 8'h92);
    chk("t5_err", {11'd0, error_o}, 12'h001);
    chk("t5_inst0", inst_o, 12'h000);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h10);
    idle(3);
    chk("t5_no_inst", 12'(inst_pulses), 12'd0);
    chk("t5_sticky", {11'd0, error_o}, 12'h001);
    step(1'b1, 1'b0, 8'h00);
    chk("t5_cleared", {11'd0, error_o}, 12'h000);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h10);
    chk("t5_inst", inst_o, 12'h210);

    // Reset in the middle of a pair
    step(1'b0, 1'b1, 8'h03);
    chk("t6_busy", {11'd0, busy_o}, 12'h001);
    inst_pulses = 0;
    step(1'b1, 1'b0, 8'h00);
    chk("t6_busy_lo", {11'd0, busy_o}, 12'h000);
    step(1'b0, 1'b1, 8'h44);
    idle(3);
    chk("t6_no_inst", 12'(inst_pulses), 12'd0);

    // Randomized traffic with varying density and rare resets
    begin
      int dens = 90;
      for (int i = 0; i < 3000; i++) begin
        logic       r_rst, r_en;
        logic [7:0] r_b;
        if (i % 64 == 0) begin
          case ($urandom_range(0, 2))
            0:       dens = 90;
            1:       dens = 50;
            default: dens = 3;
          endcase
        end
        r_rst = ($urandom_range(0, 999) < 4);
        r_en  = ($urandom_range(0, 99) < dens);
        if ($urandom_range(0, 9) < 8) r_b = {4'h0, 4'($urandom_range(0, 15))};
        else                          r_b = 8'($urandom_range(0, 255));
        step(r_rst, r_en, r_b);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
